// File: rtl/elevator_scan_controller.sv
// Elevator car controller: latches per-floor calls and serves them with a SCAN
// policy, moving one floor every TRAVEL_CYCLES clocks and holding the door DOOR_CYCLES.
module elevator_scan_controller #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8,
  localparam int FLOOR_W      = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open,
  output logic                  arrive,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]         travel_q, travel_d;
  logic [DW-1:0]         door_q, door_d;
  logic                  arrive_q, arrive_d;

  logic [FLOOR_W-1:0]    nxt_floor_s;
  logic [NUM_FLOORS-1:0] above_cur_s, below_cur_s, above_nxt_s, below_nxt_s;
  logic                  edge_ok_s;

  // Outstanding calls above/below the car now and at the floor it is about to reach.
  always_comb begin
    above_cur_s = '0;
    below_cur_s = '0;
    above_nxt_s = '0;
    below_nxt_s = '0;
    if (state_q == MOVE_UP) begin
      nxt_floor_s = floor_q + FLOOR_W'(1);
      edge_ok_s   = (floor_q != TOP_FLOOR);
    end else if (state_q == MOVE_DOWN) begin
      nxt_floor_s = floor_q - FLOOR_W'(1);
      edge_ok_s   = (floor_q != {FLOOR_W{1'b0}});
    end else begin
      nxt_floor_s = floor_q;
      edge_ok_s   = 1'b0;
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_cur_s[i] = pending_q[i] && (FLOOR_W'(i) > floor_q);
      below_cur_s[i] = pending_q[i] && (FLOOR_W'(i) < floor_q);
      above_nxt_s[i] = pending_q[i] && (FLOOR_W'(i) > nxt_floor_s);
      below_nxt_s[i] = pending_q[i] && (FLOOR_W'(i) < nxt_floor_s);
    end
  end

  // Next-state logic: SCAN decision in IDLE, floor stepping, door timing.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    travel_d  = travel_q;
    door_d    = door_q;
    arrive_d  = 1'b0;
    pending_d = pending_q | call_req;
    case (state_q)
      IDLE: begin
        if (pending_q[floor_q]) begin
          state_d            = DOOR_OPEN;
          door_d             = '0;
          arrive_d           = 1'b1;
          pending_d[floor_q] = 1'b0;
        end else if (dir_up_q && (|above_cur_s)) begin
          state_d  = MOVE_UP;
          travel_d = '0;
        end else if (dir_up_q && (|below_cur_s)) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
          travel_d = '0;
        end else if (!dir_up_q && (|below_cur_s)) begin
          state_d  = MOVE_DOWN;
          travel_d = '0;
        end else if (!dir_up_q && (|above_cur_s)) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
          travel_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (travel_q != TRAVEL_LAST) begin
          travel_d = travel_q + TW'(1);
        end else begin
          travel_d = '0;
          // The end-floor guard keeps the car in range even if the pending view is stale.
          if (edge_ok_s) begin
            floor_d = nxt_floor_s;
            if (pending_q[nxt_floor_s] || call_req[nxt_floor_s]) begin
              state_d                = DOOR_OPEN;
              door_d                 = '0;
              arrive_d               = 1'b1;
              pending_d[nxt_floor_s] = 1'b0;
            end else if ((state_q == MOVE_UP) ? (|above_nxt_s) : (|below_nxt_s)) begin
              state_d = state_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        // A call at the open floor keeps the door open instead of queuing a revisit.
        pending_d[floor_q] = pending_q[floor_q];
        if (call_req[floor_q]) begin
          door_d = '0;
        end else if (door_q == DOOR_LAST) begin
          state_d = IDLE;
          door_d  = '0;
        end else begin
          door_d = door_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      travel_q  <= '0;
      door_q    <= '0;
      arrive_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      travel_q  <= travel_d;
      door_q    <= door_d;
      arrive_q  <= arrive_d;
    end
  end

  assign current_floor = floor_q;
  assign dir_up        = dir_up_q;
  assign pending       = pending_q;
  assign arrive        = arrive_q;
  assign moving        = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
  assign door_open     = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Bench for elevator_scan_controller: vector table, directed corner sequences and
// randomized calls checked against a countdown-based behavioural model.
module tb_elevator_scan_controller;

  localparam int NF = 8;
  localparam int TC = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] call_req;
  logic [2:0] current_floor;
  logic       moving, dir_up, door_open, arrive;
  logic [7:0] pending;

  logic        rst16_n;
  logic [15:0] req16;
  logic [3:0]  floor16;
  logic        mov16, dir16, door16, arr16;
  logic [15:0] pend16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  elevator_scan_controller #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .call_req(call_req), .current_floor(current_floor),
    .moving(moving), .dir_up(dir_up), .door_open(door_open), .arrive(arrive), .pending(pending)
  );

  elevator_scan_controller #(.NUM_FLOORS(16), .TRAVEL_CYCLES(1), .DOOR_CYCLES(1)) dut16 (
    .clk(clk), .reset_n(rst16_n), .call_req(req16), .current_floor(floor16),
    .moving(mov16), .dir_up(dir16), .door_open(door16), .arrive(arr16), .pending(pend16)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 up, 2 down, 3 door; m_left counts remaining cycles.
  int       m_floor;
  bit       m_dir;
  bit [7:0] m_pend;
  int       m_mode;
  int       m_left;
  bit       m_arr;

  function automatic bit any_way(input bit [7:0] p, input int f, input bit up);
    for (int i = 0; i < NF; i++)
      if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic rst, input logic [7:0] req);
    bit [7:0] np;
    int t;
    np = m_pend | req;
    m_arr = 1'b0;
    if (!rst) begin
      m_floor = 0; m_dir = 1'b1; m_pend = '0; m_mode = 0; m_left = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) begin
          m_mode = 3; m_left = DC; m_arr = 1'b1; np[m_floor] = 1'b0;
        end else if (any_way(m_pend, m_floor, m_dir)) begin
          m_mode = m_dir ? 1 : 2; m_left = TC;
        end else if (any_way(m_pend, m_floor, !m_dir)) begin
          m_dir = !m_dir; m_mode = m_dir ? 1 : 2; m_left = TC;
        end
      end
      1, 2: begin
        m_left--;
        if (m_left == 0) begin
          t = m_floor + ((m_mode == 1) ? 1 : -1);
          m_floor = t;
          if (m_pend[t] || req[t]) begin
            m_mode = 3; m_left = DC; m_arr = 1'b1; np[t] = 1'b0;
          end else if (any_way(m_pend, t, m_mode == 1)) begin
            m_left = TC;
          end else begin
            m_mode = 0;
          end
        end
      end
      3: begin
        np[m_floor] = m_pend[m_floor];
        if (req[m_floor]) m_left = DC;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
      default: m_mode = 0;
    endcase
    m_pend = np;
  endtask

  task automatic tick(input logic rst, input logic [7:0] req);
    reset_n  = rst;
    call_req = req;
    @(posedge clk);
    model_step(rst, req);
    #1;
    check("floor", current_floor, m_floor);
    check("moving", moving, (m_mode == 1 || m_mode == 2));
    check("dir_up", dir_up, m_dir);
    check("door_open", door_open, (m_mode == 3));
    check("arrive", arrive, m_arr);
    check("pending", pending, m_pend);
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] floor;
    logic       mov;
    logic       door;
    logic       arr;
    logic       dir;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl[16];
  int   obs;
  int   stops[$];
  int   dir_at_1;
  int   prev, maxf, d;
  bit   done;
  int   arr16_q[$];
  logic [7:0] r;

  initial begin
    reset_n = 1'b0; call_req = '0; rst16_n = 1'b0; req16 = '0;

    // Reset state, call at the parked floor, door reload at the open floor.
    tbl[0]  = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[1]  = '{1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[2]  = '{1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
    for (int i = 3; i <= 9; i++) tbl[i] = '{1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[10] = '{1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[11] = '{1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[12] = '{1'b1, 8'h01, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00};
    tbl[13] = '{1'b1, 8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[14] = '{1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[15] = '{1'b1, 8'h04, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04};
    for (int i = 0; i < 16; i++) begin
      tick(tbl[i].rst_n, tbl[i].req);
      check($sformatf("vec%0d", i),
            {current_floor, moving, door_open, arrive, dir_up, pending},
            {tbl[i].floor, tbl[i].mov, tbl[i].door, tbl[i].arr, tbl[i].dir, tbl[i].pend});
    end

    // Single call to floor 3: latency and timing of every floor step.
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h08);
    check("r030_pend_c1", pending, 8'h08);
    tick(1'b1, 8'h00);
    check("r030_moving_c2", moving, 1);
    obs = 2;
    while (obs < 22) begin
      tick(1'b1, 8'h00);
      obs++;
      if (obs == 6)  check("r030_floor1_c6", current_floor, 1);
      if (obs == 10) check("r030_floor2_c10", current_floor, 2);
      if (obs == 14) begin
        check("r030_floor3_c14", current_floor, 3);
        check("r030_arrive_c14", arrive, 1);
        check("r030_door_c14", door_open, 1);
        check("r030_pend_c14", pending, 0);
      end
      if (obs == 21) check("r030_door_c21", door_open, 1);
    end
    check("r030_idle_c22", {moving, door_open}, 2'b00);

    // Calls behind and ahead while travelling 2 -> 6.
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h40);
    for (int n = 0; n < 60 && !(current_floor == 3'd2 && moving); n++) tick(1'b1, 8'h00);
    check("r032_reach2", (current_floor == 3'd2 && moving), 1);
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h12);
    stops.delete();
    dir_at_1 = -1;
    for (int n = 0; n < 400 && stops.size() < 3; n++) begin
      if (arrive) begin
        stops.push_back(int'(current_floor));
        if (current_floor == 3'd1) dir_at_1 = dir_up;
      end
      if (stops.size() < 3) tick(1'b1, 8'h00);
    end
    check("r032_nstops", stops.size(), 3);
    if (stops.size() == 3) begin
      check("r032_stop0", stops[0], 4);
      check("r032_stop1", stops[1], 6);
      check("r032_stop2", stops[2], 1);
    end
    check("r032_dir_at1", dir_at_1, 0);

    // Door reload at floor 5 on door count 6.
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h20);
    for (int n = 0; n < 100 && !door_open; n++) tick(1'b1, 8'h00);
    check("r033_door", door_open, 1);
    check("r033_floor5", current_floor, 5);
    for (int n = 0; n < 6; n++) tick(1'b1, 8'h00);
    tick(1'b1, 8'h20);
    for (int j = 1; j <= 8; j++) begin
      check($sformatf("r033_door_p%0d", j), door_open, 1);
      check($sformatf("r033_pend5_p%0d", j), pending[5], 0);
      tick(1'b1, 8'h00);
    end
    check("r033_closed_p9", door_open, 0);

    // Reset mid-move between floors 4 and 5.
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h80);
    for (int n = 0; n < 100 && !(current_floor == 3'd4 && moving); n++) tick(1'b1, 8'h00);
    tick(1'b1, 8'h00);
    check("r034_pend7", pending, 8'h80);
    check("r034_moving", moving, 1);
    tick(1'b0, 8'h00);
    check("r034_after_rst", {current_floor, pending, moving, dir_up, door_open},
          {3'd0, 8'h00, 1'b0, 1'b1, 1'b0});
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h00);
    check("r034_stays_idle", {moving, door_open}, 2'b00);

    // Randomized calls with occasional reset, compared cycle by cycle with the model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       r = 8'(1 << $urandom_range(0, 7));
        1:       r = 8'($urandom) & 8'($urandom);
        default: r = 8'h00;
      endcase
      tick(($urandom_range(0, 499) != 0), r);
    end

    // 16 floors, one cycle per floor and door: climb to 15 without wrap, then descend.
    rst16_n = 1'b0; req16 = '0;
    @(posedge clk); #1;
    check("r035_rst_floor", floor16, 0);
    rst16_n = 1'b1; req16 = 16'h8000;
    @(posedge clk); #1;
    check("r035_pend15", pend16, 16'h8000);
    req16 = 16'h0001;
    @(posedge clk); #1;
    req16 = 16'h0000;
    check("r035_moving", mov16, 1);
    prev = int'(floor16); maxf = prev; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (arr16) begin
        arr16_q.push_back(int'(floor16));
        if (floor16 == 4'd0) done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
        if (int'(floor16) != prev) begin
          d = int'(floor16) - prev;
          check("r035_step", (d == 1 || d == -1), 1);
          if (int'(floor16) > maxf) maxf = int'(floor16);
          prev = int'(floor16);
        end
      end
    end
    check("r035_done", done, 1);
    check("r035_max15", maxf, 15);
    check("r035_narr", arr16_q.size(), 2);
    if (arr16_q.size() == 2) begin
      check("r035_arr_top", arr16_q[0], 15);
      check("r035_arr_bot", arr16_q[1], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
